// File: rtl/div_arb_pkg.sv
// Shared definitions for the divider arbiter.
//   state_e    : FSM encoding used by div_arbiter
//   DZ_QUO_ALL : quotient reported for a zero divisor (all ones), sliced to W
package div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

    localparam logic [31:0] DZ_QUO_ALL = '1;

endpackage

// File: rtl/div_rr_pick.sv
// Combinational rotate-priority picker.
//   req      : per-requester request levels
//   last_gnt : most recently granted requester; scanning starts one above it
//   any      : at least one request present
//   winner   : first asserted request found scanning upward, wrapping modulo N
module div_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_gnt,
    output logic           any,
    output logic [IDW-1:0] winner
);

    int idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_gnt) + k) % N;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin front end sharing one sequential divider core among N requesters.
// Divide-by-zero is answered locally without starting the core.
//   clk, reset_n          : clock (rising edge), async active-low reset
//   req, dvnd_in, dvsr_in : requester levels and packed operands ([i*W +: W])
//   gnt                   : one-hot, one-cycle accept pulse
//   busy                  : state is not IDLE
//   resp_*                : result strobe, owner id, quotient, remainder, dz flag
//   div_*                 : divider core handshake and operands
//
// state | meaning
// IDLE  | waiting for a request while the core reports ready
// ISSUE | grant pulse; start the core, or answer divide-by-zero locally
// WAIT  | core running, operands held
// RESP  | result strobe for one cycle
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] dvnd_in,
    input  logic [N*W-1:0] dvsr_in,
    output logic [N-1:0]   gnt,
    output logic           busy,
    output logic           resp_valid,
    output logic [IDW-1:0] resp_id,
    output logic [W-1:0]   resp_quo,
    output logic [W-1:0]   resp_rmd,
    output logic           resp_dz,
    output logic           div_start,
    output logic [W-1:0]   div_dvnd,
    output logic [W-1:0]   div_dvsr,
    input  logic           div_ready,
    input  logic           div_done_tick,
    input  logic [W-1:0]   div_quo,
    input  logic [W-1:0]   div_rmd
);

    localparam logic [W-1:0] DZ_QUO = DZ_QUO_ALL[W-1:0];

    state_e         state_q, state_d;
    logic [IDW-1:0] last_gnt_q, last_gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   dvnd_q, dvnd_d;
    logic [W-1:0]   dvsr_q, dvsr_d;
    logic           dz_q, dz_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rmd_q, rmd_d;

    logic           pick_any;
    logic [IDW-1:0] pick_winner;

    div_rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req      (req),
        .last_gnt (last_gnt_q),
        .any      (pick_any),
        .winner   (pick_winner)
    );

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        id_d       = id_q;
        dvnd_d     = dvnd_q;
        dvsr_d     = dvsr_q;
        dz_d       = dz_q;
        quo_d      = quo_q;
        rmd_d      = rmd_q;
        case (state_q)
            IDLE: begin
                if (pick_any && div_ready) begin
                    id_d       = pick_winner;
                    last_gnt_d = pick_winner;
                    dvnd_d     = dvnd_in[int'(pick_winner)*W +: W];
                    dvsr_d     = dvsr_in[int'(pick_winner)*W +: W];
                    dz_d       = (dvsr_in[int'(pick_winner)*W +: W] == '0);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (dz_q) begin
                    quo_d   = DZ_QUO;
                    rmd_d   = dvnd_q;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (div_done_tick) begin
                    quo_d   = div_quo;
                    rmd_d   = div_rmd;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_gnt_q <= IDW'(N - 1);
            id_q       <= '0;
            dvnd_q     <= '0;
            dvsr_q     <= '0;
            dz_q       <= 1'b0;
            quo_q      <= '0;
            rmd_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            id_q       <= id_d;
            dvnd_q     <= dvnd_d;
            dvsr_q     <= dvsr_d;
            dz_q       <= dz_d;
            quo_q      <= quo_d;
            rmd_q      <= rmd_d;
        end
    end

    // Strobes come only from the state register so no input reaches an output.
    always_comb begin
        gnt = '0;
        if (state_q == ISSUE) begin
            gnt[id_q] = 1'b1;
        end
    end

    assign busy       = (state_q != IDLE);
    assign div_start  = (state_q == ISSUE) && !dz_q;
    assign resp_valid = (state_q == RESP);
    assign resp_id    = id_q;
    assign resp_quo   = quo_q;
    assign resp_rmd   = rmd_q;
    assign resp_dz    = dz_q;
    assign div_dvnd   = dvnd_q;
    assign div_dvsr   = dvsr_q;

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] dvnd_in, dvsr_in;
    logic [N-1:0]   gnt;
    logic           busy, resp_valid, resp_dz, div_start;
    logic [IDW-1:0] resp_id;
    logic [W-1:0]   resp_quo, resp_rmd, div_dvnd, div_dvsr;
    logic           div_ready;
    logic           div_done_tick = 1'b0;
    logic [W-1:0]   div_quo = '0;
    logic [W-1:0]   div_rmd = '0;

    logic [W-1:0] dvnd [N];
    logic [W-1:0] dvsr [N];
    bit           ready_en = 1'b1;

    int checks = 0;
    int errors = 0;
    int ptr = N - 1;

    always #5 clk = ~clk;

    always_comb begin
        dvnd_in = '0;
        dvsr_in = '0;
        for (int i = 0; i < N; i++) begin
            dvnd_in[i*W +: W] = dvnd[i];
            dvsr_in[i*W +: W] = dvsr[i];
        end
    end

    div_arbiter #(.W(W), .N(N), .IDW(IDW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .dvnd_in       (dvnd_in),
        .dvsr_in       (dvsr_in),
        .gnt           (gnt),
        .busy          (busy),
        .resp_valid    (resp_valid),
        .resp_id       (resp_id),
        .resp_quo      (resp_quo),
        .resp_rmd      (resp_rmd),
        .resp_dz       (resp_dz),
        .div_start     (div_start),
        .div_dvnd      (div_dvnd),
        .div_dvsr      (div_dvsr),
        .div_ready     (div_ready),
        .div_done_tick (div_done_tick),
        .div_quo       (div_quo),
        .div_rmd       (div_rmd)
    );

    // Behavioural divider core with random latency; deliberately not reset by
    // reset_n so a result can land while the arbiter sits in IDLE.
    int           core_cnt = 0;
    logic [W-1:0] core_a = '0;
    logic [W-1:0] core_b = '0;

    assign div_ready = (core_cnt == 0) && ready_en;

    always @(posedge clk) begin
        div_done_tick <= 1'b0;
        if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                div_done_tick <= 1'b1;
                div_quo       <= core_a / core_b;
                div_rmd       <= core_a % core_b;
            end
        end else if (div_start === 1'b1) begin
            core_a   <= div_dvnd;
            core_b   <= div_dvsr;
            core_cnt <= int'($urandom_range(1, 5));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first requester asserting, visiting ids in the
    // order ptr+1, ptr+2, ... around the ring.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        int order [$];
        for (int k = 1; k <= N; k++) order.push_back((p + k) % N);
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    // One transaction from the current req vector. keep leaves the winner's
    // req high after its grant; gnt_now means the grant cycle is already here.
    task automatic txn(input bit keep, input bit gnt_now);
        int           w, k;
        bit           edz, prev_done;
        logic [W-1:0] eq, er;
        w = model_pick(req, ptr);
        if (w < 0) return;
        edz = (dvsr[w] == '0);
        if (edz) begin
            eq = '1;
            er = dvnd[w];
        end else begin
            eq = dvnd[w] / dvsr[w];
            er = dvnd[w] % dvsr[w];
        end
        if (!gnt_now) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (gnt === '0 && k < 40);
        end
        check("gnt", 32'(gnt), 32'(1 << w));
        check("div_start", 32'(div_start), 32'(!edz));
        check("busy_issue", 32'(busy), 32'd1);
        ptr = w;
        if (!keep) req[w] = 1'b0;
        @(negedge clk);
        check("gnt_pulse", 32'(gnt), 32'd0);
        if (edz) begin
            check("dz_resp_latency", 32'(resp_valid), 32'd1);
            check("dz_no_start", 32'(div_start), 32'd0);
        end else begin
            check("div_dvnd_hold", 32'(div_dvnd), 32'(dvnd[w]));
            check("div_dvsr_hold", 32'(div_dvsr), 32'(dvsr[w]));
            prev_done = 1'b0;
            k = 0;
            while (resp_valid !== 1'b1 && k < 60) begin
                prev_done = div_done_tick;
                @(negedge clk);
                k++;
            end
            check("resp_after_done", {30'd0, resp_valid, prev_done}, 32'd3);
        end
        check("resp_id", 32'(resp_id), 32'(w));
        check("resp_quo", 32'(resp_quo), 32'(eq));
        check("resp_rmd", 32'(resp_rmd), 32'(er));
        check("resp_dz", 32'(resp_dz), 32'(edz));
    endtask

    initial begin
        int k;
        for (int i = 0; i < N; i++) begin
            dvnd[i] = '0;
            dvsr[i] = 8'd1;
        end

        // Reset state
        #3;
        check("rst_ctl", {24'd0, gnt, busy, resp_valid, div_start, resp_dz},
              32'd0);
        check("rst_data", {resp_id, resp_quo, resp_rmd, div_dvnd[5:0]}, 32'd0);
        check("rst_dvsr", 32'(div_dvsr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // First transaction: 200 / 7
        dvnd[0] = 8'd200;
        dvsr[0] = 8'd7;
        req = 4'b0001;
        txn(1'b0, 1'b0);

        // All four requesting, re-asserting after service
        for (int i = 0; i < N; i++) begin
            dvnd[i] = W'($urandom_range(0, 255));
            dvsr[i] = W'($urandom_range(1, 255));
        end
        req = 4'b1111;
        repeat (5) txn(1'b1, 1'b0);
        req = '0;

        // Divide by zero handled locally
        dvnd[2] = 8'd45;
        dvsr[2] = 8'd0;
        req = 4'b0100;
        txn(1'b0, 1'b0);

        // Requesters 0 and 3 held continuously
        dvnd[0] = 8'd100; dvsr[0] = 8'd10;
        dvnd[3] = 8'd100; dvsr[3] = 8'd10;
        req = 4'b1001;
        repeat (4) txn(1'b1, 1'b0);
        req = '0;

        // Core not ready: nothing granted
        ready_en = 1'b0;
        dvnd[1] = 8'd99;
        dvsr[1] = 8'd9;
        req = 4'b0010;
        repeat (5) begin
            @(negedge clk);
            check("not_ready_idle", {30'd0, |gnt, busy}, 32'd0);
        end
        ready_en = 1'b1;
        @(negedge clk);
        txn(1'b0, 1'b1);

        // Reset while waiting on the core
        dvnd[0] = 8'd77;
        dvsr[0] = 8'd5;
        req = 4'b0001;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (gnt === '0 && k < 40);
        check("mid_gnt", 32'(gnt), 32'd1);
        req = '0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ctl", {24'd0, gnt, busy, resp_valid, div_start, resp_dz},
              32'd0);
        check("mid_rst_data", {resp_id, resp_quo, resp_rmd, div_dvnd[5:0]}, 32'd0);
        check("mid_rst_dvsr", 32'(div_dvsr), 32'd0);
        ptr = N - 1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("post_rst_quiet", {30'd0, resp_valid, busy}, 32'd0);
        end
        dvnd[3] = 8'd250;
        dvsr[3] = 8'd3;
        req = 4'b1000;
        txn(1'b0, 1'b0);
        dvnd[0] = 8'd9;
        dvsr[0] = 8'd2;
        dvnd[3] = 8'd17;
        dvsr[3] = 8'd4;
        req = 4'b1001;
        txn(1'b0, 1'b0);
        txn(1'b0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    req[i]  = 1'b1;
                    dvnd[i] = W'($urandom_range(0, 255));
                    dvsr[i] = ($urandom_range(0, 5) == 0) ? '0
                                                          : W'($urandom_range(1, 255));
                end
            end
            if (req == '0) req[t % N] = 1'b1;
            txn(bit'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
